// File: rtl/tof_i2c_pkg.sv
// Shared definitions for the ToF I2C driver blocks: sequencer states,
// default stall timeout and the sensor's fixed I2C address.
package tof_i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_START,
      ST_RUN,
      ST_FINISH,
      ST_ABORT
   } seq_state_t;

   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 200000;
   localparam logic [6:0]  TOF_SLAVE_ADDR         = 7'h29;

endpackage

// File: rtl/tof_i2c_sequencer_if.sv
// Request/stream bus between ToF control logic, the sequencer and the I2C byte engine.
// slave: the sequencer's view; master: the requester/engine side.
interface tof_i2c_sequencer_if #(
   parameter int unsigned LEN_W = 8
);
   logic             req_valid;
   logic             req_ready;
   logic [6:0]       req_slave_addr;
   logic [15:0]      req_reg_addr;
   logic             req_is_read;
   logic [LEN_W-1:0] req_len;
   logic [7:0]       wr_data;
   logic             wr_valid;
   logic             wr_ready;
   logic [7:0]       rd_data;
   logic             rd_valid;
   logic             done;
   logic             error;
   logic             busy;
   logic             eng_start;
   logic [6:0]       eng_slave_addr;
   logic [15:0]      eng_reg_addr;
   logic             eng_is_read;
   logic [16:0]      eng_nb_of_bytes;
   logic [7:0]       eng_data_in;
   logic [7:0]       eng_data_out;
   logic             eng_ready;
   logic             eng_reset;

   modport slave (
      input  req_valid, req_slave_addr, req_reg_addr, req_is_read, req_len,
             wr_data, wr_valid, eng_data_out, eng_ready,
      output req_ready, wr_ready, rd_data, rd_valid, done, error, busy,
             eng_start, eng_slave_addr, eng_reg_addr, eng_is_read,
             eng_nb_of_bytes, eng_data_in, eng_reset
   );

   modport master (
      output req_valid, req_slave_addr, req_reg_addr, req_is_read, req_len,
             wr_data, wr_valid, eng_data_out, eng_ready,
      input  req_ready, wr_ready, rd_data, rd_valid, done, error, busy,
             eng_start, eng_slave_addr, eng_reg_addr, eng_is_read,
             eng_nb_of_bytes, eng_data_in, eng_reset
   );
endinterface

// File: rtl/tof_i2c_watchdog.sv
// Loadable cycle counter with clear and enable; terminal flags the enabled
// cycle whose increment would bring the count to TERMINAL.
module tof_i2c_watchdog #(
   parameter int unsigned TERMINAL = tof_i2c_pkg::TIMEOUT_CYCLES_DEFAULT,
   parameter int unsigned WIDTH    = $clog2(TERMINAL + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   output logic             terminal
);
   logic [WIDTH-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable) begin
         count <= count + WIDTH'(1);
      end
   end

   assign terminal = enable & (count == WIDTH'(TERMINAL - 1));
endmodule

// File: rtl/tof_i2c_sequencer.sv
// One-at-a-time register-access sequencer in front of the ToF I2C byte engine,
// streaming write/read bytes and aborting the engine on a byte-strobe stall.
module tof_i2c_sequencer
   import tof_i2c_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
   parameter int unsigned LEN_W          = 8
) (
   input logic                clock,
   input logic                reset,
   tof_i2c_sequencer_if.slave bus
);
   seq_state_t       state, state_nxt;
   logic [LEN_W-1:0] remaining, remaining_dec;
   logic [6:0]       slave_addr;
   logic [15:0]      reg_addr;
   logic             is_read;
   logic             first_byte;
   logic [16:0]      nb_bytes;
   logic [7:0]       data_in;
   logic [7:0]       rd_data;
   logic             rd_valid;
   logic             eng_ready_q;
   logic             strb;
   logic             wd_terminal;

   assign strb          = bus.eng_ready & ~eng_ready_q;
   assign remaining_dec = remaining - LEN_W'(1);

   // A strobe anywhere (including a late one seen in FETCH) restarts the stall window.
   tof_i2c_watchdog #(.TERMINAL(TIMEOUT_CYCLES)) u_watchdog (
      .clock      (clock),
      .reset      (reset),
      .clear      (strb | (state == ST_START)),
      .load       (1'b0),
      .load_value ('0),
      .enable     (state == ST_RUN),
      .terminal   (wd_terminal)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         eng_ready_q <= 1'b0;
         remaining   <= '0;
         slave_addr  <= '0;
         reg_addr    <= '0;
         is_read     <= 1'b0;
         first_byte  <= 1'b0;
         nb_bytes    <= '0;
         data_in     <= '0;
         rd_data     <= '0;
         rd_valid    <= 1'b0;
      end else begin
         eng_ready_q <= bus.eng_ready;
         rd_valid    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  slave_addr <= bus.req_slave_addr;
                  reg_addr   <= bus.req_reg_addr;
                  is_read    <= bus.req_is_read;
                  remaining  <= bus.req_len;
                  first_byte <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (bus.wr_valid) begin
                  data_in <= bus.wr_data;
               end
            end
            ST_START: begin
               nb_bytes   <= 17'(remaining);
               first_byte <= 1'b0;
            end
            ST_RUN: begin
               if (strb) begin
                  if (is_read) begin
                     rd_data  <= bus.eng_data_out;
                     rd_valid <= 1'b1;
                  end
                  if (remaining != '0) begin
                     remaining <= remaining_dec;
                     nb_bytes  <= 17'(remaining_dec);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt     = state;
      bus.req_ready = 1'b0;
      bus.wr_ready  = 1'b0;
      bus.eng_start = 1'b0;
      bus.done      = 1'b0;
      bus.error     = 1'b0;
      bus.busy      = 1'b0;
      bus.eng_reset = reset & (state != ST_IDLE);
      case (state)
         ST_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               state_nxt = bus.req_is_read ? ST_START : ST_FETCH;
            end
         end
         ST_FETCH: begin
            bus.busy     = 1'b1;
            bus.wr_ready = bus.wr_valid;
            if (bus.wr_valid) begin
               state_nxt = first_byte ? ST_START : ST_RUN;
            end
         end
         ST_START: begin
            bus.busy      = 1'b1;
            bus.eng_start = 1'b1;
            state_nxt     = ST_RUN;
         end
         ST_RUN: begin
            bus.busy = 1'b1;
            // A strobe on the terminal cycle still counts as progress.
            if (strb) begin
               if (remaining == '0) begin
                  state_nxt = ST_FINISH;
               end else begin
                  state_nxt = is_read ? ST_RUN : ST_FETCH;
               end
            end else if (wd_terminal) begin
               state_nxt = ST_ABORT;
            end
         end
         ST_FINISH: begin
            bus.done  = 1'b1;
            state_nxt = ST_IDLE;
         end
         ST_ABORT: begin
            bus.done      = 1'b1;
            bus.error     = 1'b1;
            bus.eng_reset = 1'b1;
            state_nxt     = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign bus.eng_slave_addr  = slave_addr;
   assign bus.eng_reg_addr    = reg_addr;
   assign bus.eng_is_read     = is_read;
   assign bus.eng_nb_of_bytes = nb_bytes;
   assign bus.eng_data_in     = data_in;
   assign bus.rd_data         = rd_data;
   assign bus.rd_valid        = rd_valid;
endmodule

// File: tb/tb_tof_i2c_sequencer.sv
// Randomized bench for tof_i2c_sequencer: a behavioural requester and byte engine
// drive transactions; a monitor logs events that are compared to per-transaction expectations.
module tb_tof_i2c_sequencer;
   import tof_i2c_pkg::*;

   localparam int unsigned TO    = 50;
   localparam int unsigned LEN_W = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   tof_i2c_sequencer_if #(.LEN_W(LEN_W)) bus ();

   tof_i2c_sequencer #(.TIMEOUT_CYCLES(TO), .LEN_W(LEN_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // transaction expectations
   logic [7:0]  eng_bytes[$];
   logic [7:0]  wr_bytes[$];
   logic [6:0]  exp_slave;
   logic [15:0] exp_reg;
   logic        exp_rd;
   int unsigned hold_fixed;

   // monitor log
   int unsigned cyc, acc_cnt, start_cnt, done_cnt, hs_cnt, wr_viol, hold_viol, eng_rst_cnt;
   int unsigned acc_cyc, hs0_cyc, start_cyc, done_cyc, last_strb_cyc;
   logic        last_err, done_busy, done_rst, prev_rdy;
   logic [16:0] nb_q[$];
   logic [7:0]  din_q[$];
   logic [7:0]  rd_q[$];

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (!reset) begin
         if (bus.req_valid && bus.req_ready) begin acc_cnt++; acc_cyc = cyc; end
         if (bus.wr_valid && bus.wr_ready) begin
            if (hs_cnt == 0) hs0_cyc = cyc;
            hs_cnt++;
         end
         if (bus.wr_ready && !bus.wr_valid) wr_viol++;
         if (bus.eng_start) begin start_cnt++; start_cyc = cyc; end
         if (bus.eng_ready && !prev_rdy) begin
            nb_q.push_back(bus.eng_nb_of_bytes);
            din_q.push_back(bus.eng_data_in);
            last_strb_cyc = cyc;
         end
         if (bus.rd_valid) rd_q.push_back(bus.rd_data);
         if (bus.done) begin
            done_cnt++; done_cyc = cyc;
            last_err = bus.error; done_busy = bus.busy; done_rst = bus.eng_reset;
         end
         if (bus.eng_reset) eng_rst_cnt++;
         if (bus.busy && (bus.eng_slave_addr !== exp_slave || bus.eng_reg_addr !== exp_reg ||
                          bus.eng_is_read !== exp_rd)) hold_viol++;
      end
      prev_rdy = bus.eng_ready;
   end

   task automatic prep(input bit is_rd, input int unsigned len);
      eng_bytes.delete(); wr_bytes.delete();
      for (int unsigned k = 0; k < len; k++) begin
         eng_bytes.push_back(8'($urandom));
         wr_bytes.push_back(8'($urandom));
      end
      exp_rd = is_rd; exp_slave = 7'($urandom); exp_reg = 16'($urandom); hold_fixed = 0;
      acc_cnt = 0; start_cnt = 0; done_cnt = 0; hs_cnt = 0; wr_viol = 0; hold_viol = 0;
      eng_rst_cnt = 0; last_err = 1'b0; done_busy = 1'b0; done_rst = 1'b0;
      nb_q.delete(); din_q.delete(); rd_q.delete();
   endtask

   // Presents the request, then keeps req_valid up one more cycle with junk fields.
   task automatic send_req(input int unsigned len);
      @(posedge clock); #1;
      bus.req_slave_addr = exp_slave;
      bus.req_reg_addr   = exp_reg;
      bus.req_is_read    = exp_rd;
      bus.req_len        = LEN_W'(len - 1);
      bus.req_valid      = 1'b1;
      @(negedge clock);
      check_val("req_ready_before_accept", 32'(bus.req_ready), 1);
      @(posedge clock); #1;
      bus.req_slave_addr = 7'($urandom);
      bus.req_reg_addr   = 16'($urandom);
      bus.req_is_read    = ~exp_rd;
      bus.req_len        = LEN_W'($urandom);
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic requester(input int unsigned len, input int unsigned slow_idx);
      for (int unsigned k = 0; k < len; k++) begin
         int unsigned g = 0;
         int unsigned d = (k == slow_idx) ? 20 : $urandom_range(0, 3);
         repeat (d) @(posedge clock);
         #1;
         bus.wr_data  = wr_bytes[k];
         bus.wr_valid = 1'b1;
         do begin @(negedge clock); g++; end while (!bus.wr_ready && g < 500);
         if (!bus.wr_ready) begin
            check_val("wr_handshake_wait", 0, 1);
            bus.wr_valid = 1'b0;
            return;
         end
         @(posedge clock); #1;
         bus.wr_valid = 1'b0;
         bus.wr_data  = 8'($urandom);
      end
   endtask

   // Byte engine: one rising eng_ready per completed byte, optionally long holds.
   task automatic engine_model(input int unsigned n_serve);
      for (int unsigned k = 0; k < n_serve; k++) begin
         int unsigned g = 0;
         int unsigned d, h;
         if (exp_rd) begin
            while (start_cnt == 0 && g < 1000) begin @(negedge clock); g++; end
            d = $urandom_range(1, 6);
         end else begin
            while (hs_cnt <= k && g < 1000) begin @(negedge clock); g++; end
            d = $urandom_range(2, 6);
         end
         if (g >= 1000) begin check_val("engine_wait", 0, 1); return; end
         h = (hold_fixed != 0) ? hold_fixed : $urandom_range(1, 5);
         repeat (d) @(posedge clock);
         #1;
         bus.eng_data_out = exp_rd ? eng_bytes[k] : 8'($urandom);
         bus.eng_ready    = 1'b1;
         repeat (h) @(posedge clock);
         #1;
         bus.eng_ready = 1'b0;
      end
   endtask

   task automatic wait_done();
      int unsigned g = 0;
      while (done_cnt == 0 && g < 12000) begin @(negedge clock); g++; end
      if (done_cnt == 0) check_val("done_wait", 0, 1);
   endtask

   task automatic run_txn(input string name, input int unsigned len,
                          input int unsigned n_serve, input int unsigned slow_idx);
      bit          aborted = (n_serve < len);
      int unsigned ref_cyc;
      send_req(len);
      fork
         begin if (!exp_rd) requester(len, slow_idx); end
         engine_model(n_serve);
         wait_done();
      join
      @(negedge clock);
      check_val({name, "_req_ready_after"}, 32'(bus.req_ready), 1);
      check_val({name, "_busy_after"}, 32'(bus.busy), 0);
      check_val({name, "_accepts"}, acc_cnt, 1);
      check_val({name, "_starts"}, start_cnt, 1);
      check_val({name, "_start_latency"}, start_cyc, (exp_rd ? acc_cyc : hs0_cyc) + 1);
      check_val({name, "_dones"}, done_cnt, 1);
      check_val({name, "_error"}, 32'(last_err), 32'(aborted));
      check_val({name, "_busy_at_done"}, 32'(done_busy), 0);
      check_val({name, "_eng_reset_at_done"}, 32'(done_rst), 32'(aborted));
      check_val({name, "_eng_reset_pulses"}, eng_rst_cnt, aborted ? 1 : 0);
      check_val({name, "_addr_hold"}, hold_viol, 0);
      check_val({name, "_wr_ready_only_fetch"}, wr_viol, 0);
      check_val({name, "_wr_handshakes"}, hs_cnt, exp_rd ? 0 : len);
      check_val({name, "_strobes"}, nb_q.size(), n_serve);
      for (int unsigned k = 0; k < nb_q.size() && k < n_serve; k++) begin
         check_val($sformatf("%s_nb_%0d", name, k), 32'(nb_q[k]), len - 1 - k);
         if (!exp_rd) check_val($sformatf("%s_din_%0d", name, k), 32'(din_q[k]), 32'(wr_bytes[k]));
      end
      if (exp_rd) begin
         check_val({name, "_rd_count"}, rd_q.size(), n_serve);
         for (int unsigned k = 0; k < rd_q.size() && k < n_serve; k++)
            check_val($sformatf("%s_rd_%0d", name, k), 32'(rd_q[k]), 32'(eng_bytes[k]));
      end
      if (aborted) begin
         ref_cyc = (n_serve == 0) ? start_cyc : last_strb_cyc;
         check_val({name, "_abort_cycle"}, done_cyc - ref_cyc, TO + 1);
      end
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, "_req_ready"}, 32'(bus.req_ready), 1);
      check_val({tag, "_wr_ready"}, 32'(bus.wr_ready), 0);
      check_val({tag, "_rd_valid"}, 32'(bus.rd_valid), 0);
      check_val({tag, "_done"}, 32'(bus.done), 0);
      check_val({tag, "_error"}, 32'(bus.error), 0);
      check_val({tag, "_busy"}, 32'(bus.busy), 0);
      check_val({tag, "_eng_start"}, 32'(bus.eng_start), 0);
      check_val({tag, "_eng_reset"}, 32'(bus.eng_reset), 0);
      check_val({tag, "_eng_nb"}, 32'(bus.eng_nb_of_bytes), 0);
      check_val({tag, "_eng_data_in"}, 32'(bus.eng_data_in), 0);
      check_val({tag, "_rd_data"}, 32'(bus.rd_data), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      bus.req_valid = 1'b0; bus.req_slave_addr = '0; bus.req_reg_addr = '0;
      bus.req_is_read = 1'b0; bus.req_len = '0; bus.wr_data = '0; bus.wr_valid = 1'b0;
      bus.eng_data_out = '0; bus.eng_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check_idle("reset");

      prep(1, 1); exp_slave = TOF_SLAVE_ADDR; exp_reg = 16'h010F; eng_bytes[0] = 8'hEA;
      run_txn("rd1", 1, 1, 999);

      prep(0, 3); exp_slave = TOF_SLAVE_ADDR; exp_reg = 16'h0088;
      wr_bytes[0] = 8'h11; wr_bytes[1] = 8'h22; wr_bytes[2] = 8'h33;
      run_txn("wr3", 3, 3, 999);

      prep(1, 4); hold_fixed = 5;
      run_txn("rd4_hold5", 4, 4, 999);

      prep(1, 1);
      run_txn("timeout", 1, 0, 999);

      prep(1, 4);
      run_txn("partial_abort", 4, 2, 999);

      prep(0, 3);
      run_txn("wr_slow", 3, 3, 1);

      // reset while the engine is stalled in the middle of a read
      prep(1, 4);
      send_req(4);
      repeat (10) @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      check_val("midrst_eng_reset", 32'(bus.eng_reset), 1);
      @(posedge clock); #1 reset = 1'b0;
      @(negedge clock);
      check_idle("midrst");
      repeat (TO + 10) @(negedge clock);
      check_val("midrst_no_done", done_cnt, 0);
      check_val("midrst_no_rd", rd_q.size(), 0);
      prep(1, 2);
      run_txn("after_rst", 2, 2, 999);

      prep(1, 256);
      run_txn("rd256", 256, 256, 999);
      prep(0, 1);
      run_txn("wr1", 1, 1, 999);

      for (int unsigned i = 0; i < 10; i++) begin
         bit          rd  = 1'($urandom_range(0, 1));
         int unsigned len = $urandom_range(1, 9);
         prep(rd, len);
         run_txn($sformatf("rand%0d", i), len, len, 999);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/tof_i2c_sequencer.md
Name: tof_i2c_sequencer

Overview:
- Transaction sequencer directly upstream of the ToF I2C byte engine.
- Accepts one register-access request at a time from the ToF control logic and drives the engine's start, addressing, byte-count and data_in inputs.
- Streams write bytes in from the requester and read bytes (engine data_out) back to it.
- Detects engine stalls with a timeout and reports status per transaction.

Parameters:
- TIMEOUT_CYCLES, 200000, max clock cycles between engine byte strobes before abort
- LEN_W, 8, width of request length field; transfer = req_len+1 bytes (1..2^LEN_W)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept request (IDLE only)
- req_slave_addr  in  7  7-bit I2C slave address
- req_reg_addr  in  16  16-bit sensor register index
- req_is_read  in  1  1=read, 0=write
- req_len  in  LEN_W  byte count minus one
- wr_data  in  8  write byte stream
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  wr_data consumed this cycle
- rd_data  out  8  read byte
- rd_valid  out  1  one-cycle pulse, rd_data valid
- done  out  1  one-cycle pulse at transaction end
- error  out  1  valid with done; 1=timeout abort
- busy  out  1  transaction in progress
- eng_start  out  1  one-cycle start pulse to engine
- eng_slave_addr  out  7  held stable for whole transaction
- eng_reg_addr  out  16  held stable
- eng_is_read  out  1  held stable
- eng_nb_of_bytes  out  17  bytes remaining after the byte in flight
- eng_data_in  out  8  byte engine is serialising
- eng_data_out  in  8  byte received by engine
- eng_ready  in  1  engine byte-boundary indication
- eng_reset  out  1  engine reset, asserted on abort

Behaviour:
- Reset values: req_ready=1, wr_ready=0, rd_valid=0, done=0, error=0, busy=0, eng_start=0, eng_reset=0, eng_nb_of_bytes=0, eng_data_in=0, rd_data=0, state IDLE. Reset mid-transaction returns to IDLE immediately and pulses nothing; eng_reset is asserted the same cycle.
- Byte strobe: strb = eng_ready & ~eng_ready_q (rising edge, one register); each strb counts one completed byte.
- States:
  - IDLE: req_ready=1. On req_valid, latch all request fields, remaining=req_len, busy=1. Write -> FETCH; read -> START.
  - FETCH (write only): wr_ready=wr_valid; on wr_valid, eng_data_in<=wr_data -> START (first byte) or RUN (subsequent). No timeout while waiting for wr_valid.
  - START: eng_nb_of_bytes<=remaining, eng_start=1 for exactly one cycle -> RUN; timeout counter cleared.
  - RUN: timeout counter increments each cycle, clears on strb. On strb:
    - write with remaining>0: remaining--, eng_nb_of_bytes<=remaining-1 the same cycle -> FETCH.
    - write with remaining==0 -> FINISH.
    - read: rd_data<=eng_data_out, rd_valid=1 next cycle; remaining>0: remaining--, eng_nb_of_bytes updated -> RUN; remaining==0 -> FINISH.
    - Counter reaching TIMEOUT_CYCLES -> ABORT.
  - FINISH: done=1, error=0 for one cycle, busy=0 -> IDLE.
  - ABORT: eng_reset=1 for one cycle, done=1, error=1 -> IDLE. Partial read bytes already delivered remain delivered.
- Write strb arriving while in FETCH (requester late): strb ignored except for its timeout clear; engine protocol holds data_in until the next boundary.
- Simultaneous strb and timeout terminal count: strb wins.
- req_valid while busy: ignored (req_ready=0).
- Latency: req accept -> eng_start = 1 cycle (read), 1 cycle after first wr_valid (write).
- Widths: remaining is LEN_W bits, zero-extended into 17-bit eng_nb_of_bytes.

Decomposition:
- Package tof_i2c_pkg holds:
  - state encodings (IDLE, FETCH, START, RUN, FINISH, ABORT)
  - default TIMEOUT_CYCLES
  - ToF slave address constant 7'h29
- Sub-module tof_i2c_watchdog: loadable counter with clear, enable and terminal-count output. Reusable by other ToF driver blocks.

Test Plan:
- Read of 1 byte, slave 7'h29, reg 16'h010F, engine model returns 8'hEA -> one eng_start, eng_nb_of_bytes=0, single rd_valid with rd_data=8'hEA, done=1, error=0.
- Write of 3 bytes 8'h11, 8'h22, 8'h33 to reg 16'h0088 -> eng_nb_of_bytes sequence 2,1,0; eng_data_in matches each byte at each strb; done after third strb.
- Read of 4 bytes with eng_ready held high 5 cycles per byte -> exactly 4 rd_valid pulses (no double counting), order preserved.
- Engine model never asserts eng_ready, TIMEOUT_CYCLES=50 -> ABORT at cycle 50 of RUN: eng_reset pulse, done=1, error=1, busy=0, req_ready=1.
- Write with wr_valid delayed 20 cycles for byte 2 -> no timeout, wr_ready asserted only in FETCH, transaction completes cleanly.
- Reset asserted mid-RUN of a 4-byte read -> next cycle outputs at reset values, no done pulse, a new request is accepted afterwards.
